// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame writer: HD44780 instruction codes,
// the custom glyph ROM (bell at CGRAM char 0, hourglass at char 1), the
// power-on instruction list and the top-level sequencer state type.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CGRAM0   = 8'h40;
    localparam logic [7:0] DDRAM_L1 = 8'h80;
    localparam logic [7:0] DDRAM_L2 = 8'hC0;

    localparam int unsigned INIT_LEN = 6;

    typedef enum logic [2:0] {
        ST_POWER_WAIT,
        ST_INIT,
        ST_CGRAM,
        ST_FRAME,
        ST_IDLE
    } lcd_state_t;

    // Power-on instruction list, issued in order.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_byte = FUNC_SET;
            3'd3:             init_byte = DISP_ON;
            3'd4:             init_byte = CLEAR;
            3'd5:             init_byte = ENTRY;
            default:          init_byte = FUNC_SET;
        endcase
    endfunction

    // Rows 0-7 are the alarm bell, rows 8-15 the timer hourglass.
    function automatic logic [7:0] glyph_byte(input logic [3:0] idx);
        case (idx)
            4'd0:  glyph_byte = 8'h04;
            4'd1:  glyph_byte = 8'h0E;
            4'd2:  glyph_byte = 8'h0E;
            4'd3:  glyph_byte = 8'h0E;
            4'd4:  glyph_byte = 8'h1F;
            4'd5:  glyph_byte = 8'h00;
            4'd6:  glyph_byte = 8'h04;
            4'd7:  glyph_byte = 8'h00;
            4'd8:  glyph_byte = 8'h1F;
            4'd9:  glyph_byte = 8'h11;
            4'd10: glyph_byte = 8'h0A;
            4'd11: glyph_byte = 8'h04;
            4'd12: glyph_byte = 8'h0A;
            4'd13: glyph_byte = 8'h11;
            4'd14: glyph_byte = 8'h1F;
            default: glyph_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Writes one byte to the LCD bus as SETUP (1 cycle, E low), PULSE (EPulse
// cycles, E high) and HOLD (wait_cycles cycles, E low). DB/RS are captured
// at start and held until the next accepted start.
// Ports: mclk, rst (sync, active-high); start/rs/data/wait_cycles request;
// DB/RS/E registered bus outputs; done_c high in the last HOLD cycle, when a
// new start is accepted with no gap cycle.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned EPulse = 2
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        start,
    input  logic        rs,
    input  logic [7:0]  data,
    input  logic [31:0] wait_cycles,
    output logic [7:0]  DB,
    output logic        RS,
    output logic        E,
    output logic        done_c
);

    localparam logic [31:0] EP_LAST = 32'((EPulse > 0) ? EPulse - 1 : 0);

    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD} wphase_t;

    wphase_t     phase, phase_d;
    logic [31:0] cnt, cnt_d;
    logic [31:0] wait_q, wait_d;
    logic [7:0]  db_d;
    logic        rs_d;
    logic        e_d;
    logic        take;

    // Phase register and registered bus outputs.
    always_ff @(posedge mclk) begin
        if (rst) begin
            phase  <= W_IDLE;
            cnt    <= '0;
            wait_q <= '0;
            DB     <= '0;
            RS     <= 1'b0;
            E      <= 1'b0;
        end else begin
            phase  <= phase_d;
            cnt    <= cnt_d;
            wait_q <= wait_d;
            DB     <= db_d;
            RS     <= rs_d;
            E      <= e_d;
        end
    end

    // Phase sequencing; a start is taken when idle or in the last HOLD cycle.
    always_comb begin
        phase_d = phase;
        cnt_d   = cnt;
        wait_d  = wait_q;
        db_d    = DB;
        rs_d    = RS;
        done_c  = 1'b0;
        take    = 1'b0;
        case (phase)
            W_IDLE:  take = start;
            W_SETUP: begin
                phase_d = W_PULSE;
                cnt_d   = '0;
            end
            W_PULSE: begin
                if (cnt == EP_LAST) begin
                    phase_d = W_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            W_HOLD: begin
                if (cnt == wait_q - 32'd1) begin
                    done_c  = 1'b1;
                    phase_d = W_IDLE;
                    take    = start;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            default: phase_d = W_IDLE;
        endcase
        if (take) begin
            phase_d = W_SETUP;
            db_d    = data;
            rs_d    = rs;
            // A zero hold would never reach done; treat it as one cycle.
            wait_d  = (wait_cycles == 32'd0) ? 32'd1 : wait_cycles;
        end
        e_d = (phase_d == W_PULSE);
    end

endmodule

// File: rtl/lcd_frame_writer.sv
// Drives a 16x2 HD44780-compatible LCD: power-on wait, init instructions,
// two custom glyphs into CGRAM, then continuous frames of LineA/LineB with
// a refresh gap. Both lines are snapshotted when each frame starts.
// Ports: mclk, rst (sync, active-high); LineA/LineB 16-char images (column
// 0 in bits [7:0]); DB/RS/E/RW LCD write bus (RW tied low); frame_done
// one-cycle pulse after the last byte of each frame.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int unsigned M_FREQ       = 1,
    parameter int unsigned InsWaitTime  = 10,
    parameter int unsigned DataWaitTime = 10,
    parameter int unsigned RefreshTime  = 320,
    parameter int unsigned EPulse       = 2
) (
    input  logic         mclk,
    input  logic         rst,
    input  logic [127:0] LineA,
    input  logic [127:0] LineB,
    output logic [7:0]   DB,
    output logic         RS,
    output logic         E,
    output logic         RW,
    output logic         frame_done
);

    localparam int unsigned POWER_WAIT = (M_FREQ / 25 >= 1) ? M_FREQ / 25 : 1;
    localparam int unsigned CLEAR_WAIT =
        (M_FREQ / 500 > InsWaitTime) ? M_FREQ / 500 : InsWaitTime;
    localparam logic [31:0] PW_LAST  = 32'(POWER_WAIT - 1);
    localparam logic [31:0] REF_LAST = 32'((RefreshTime > 0) ? RefreshTime - 1 : 0);
    localparam logic [31:0] INS_W    = 32'(InsWaitTime);
    localparam logic [31:0] DATA_W   = 32'(DataWaitTime);
    localparam logic [31:0] CLEAR_W  = 32'(CLEAR_WAIT);
    localparam logic [3:0]  INIT_LAST = 4'(INIT_LEN - 1);

    lcd_state_t   state, state_d;
    logic [31:0]  cnt, cnt_d;
    logic [3:0]   col, col_d;
    logic         line, line_d;
    logic         on_addr, on_addr_d;
    logic [127:0] shadow_a, shadow_b;
    logic [127:0] line_img;

    logic         start_c;
    logic         byte_rs;
    logic [7:0]   byte_data;
    logic [31:0]  byte_wait;
    logic         done_c;

    assign RW = 1'b0;

    lcd_byte_writer #(.EPulse(EPulse)) u_byte (
        .mclk        (mclk),
        .rst         (rst),
        .start       (start_c),
        .rs          (byte_rs),
        .data        (byte_data),
        .wait_cycles (byte_wait),
        .DB          (DB),
        .RS          (RS),
        .E           (E),
        .done_c      (done_c)
    );

    // Sequencer state, line snapshots and frame_done pulse.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state      <= ST_POWER_WAIT;
            cnt        <= '0;
            col        <= '0;
            line       <= 1'b0;
            on_addr    <= 1'b0;
            shadow_a   <= '0;
            shadow_b   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            col        <= col_d;
            line       <= line_d;
            on_addr    <= on_addr_d;
            frame_done <= (state_d == ST_IDLE) && (state != ST_IDLE);
            if ((state_d == ST_FRAME) && (state != ST_FRAME)) begin
                shadow_a <= LineA;
                shadow_b <= LineB;
            end
        end
    end

    // Next byte selection; each new byte is started on the writer's done.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        col_d     = col;
        line_d    = line;
        on_addr_d = on_addr;
        start_c   = 1'b0;
        byte_rs   = 1'b0;
        byte_data = 8'h00;
        byte_wait = INS_W;
        line_img  = '0;
        case (state)
            ST_POWER_WAIT: begin
                if (cnt == PW_LAST) begin
                    start_c   = 1'b1;
                    byte_data = init_byte(3'd0);
                    col_d     = '0;
                    state_d   = ST_INIT;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            ST_INIT: begin
                if (done_c) begin
                    start_c = 1'b1;
                    if (col == INIT_LAST) begin
                        byte_data = CGRAM0;
                        col_d     = '0;
                        on_addr_d = 1'b1;
                        state_d   = ST_CGRAM;
                    end else begin
                        col_d     = col + 4'd1;
                        byte_data = init_byte(col_d[2:0]);
                        if (byte_data == CLEAR) byte_wait = CLEAR_W;
                    end
                end
            end
            ST_CGRAM: begin
                if (done_c) begin
                    start_c = 1'b1;
                    if (on_addr || (col != 4'd15)) begin
                        col_d     = on_addr ? 4'd0 : col + 4'd1;
                        on_addr_d = 1'b0;
                        byte_rs   = 1'b1;
                        byte_wait = DATA_W;
                        byte_data = glyph_byte(col_d);
                    end else begin
                        byte_data = DDRAM_L1;
                        col_d     = '0;
                        line_d    = 1'b0;
                        on_addr_d = 1'b1;
                        state_d   = ST_FRAME;
                    end
                end
            end
            ST_FRAME: begin
                if (done_c) begin
                    if (on_addr || (col != 4'd15)) begin
                        start_c   = 1'b1;
                        col_d     = on_addr ? 4'd0 : col + 4'd1;
                        on_addr_d = 1'b0;
                        byte_rs   = 1'b1;
                        byte_wait = DATA_W;
                        line_img  = line ? shadow_b : shadow_a;
                        byte_data = line_img[{col_d, 3'b000} +: 8];
                    end else if (!line) begin
                        start_c   = 1'b1;
                        byte_data = DDRAM_L2;
                        col_d     = '0;
                        line_d    = 1'b1;
                        on_addr_d = 1'b1;
                    end else begin
                        col_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (cnt == REF_LAST) begin
                    start_c   = 1'b1;
                    byte_data = DDRAM_L1;
                    col_d     = '0;
                    line_d    = 1'b0;
                    on_addr_d = 1'b1;
                    state_d   = ST_FRAME;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_POWER_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed self-checking bench for lcd_frame_writer: reset, init/CGRAM
// sequence, frame content, anti-tear latching, bus timing and mid-frame reset.
module tb_lcd_frame_writer;

    logic         mclk = 1'b0;
    logic         rst;
    logic [127:0] LineA, LineB;
    logic [7:0]   DB;
    logic         RS, E, RW, frame_done;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int cyc      = 0;

    logic [8:0] cap[$];
    int         fd_q[$];

    lcd_frame_writer #(
        .M_FREQ(100), .InsWaitTime(10), .DataWaitTime(10),
        .RefreshTime(320), .EPulse(2)
    ) dut (
        .mclk(mclk), .rst(rst), .LineA(LineA), .LineB(LineB),
        .DB(DB), .RS(RS), .E(E), .RW(RW), .frame_done(frame_done)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc = cyc + 1;

    // Panel-side view: bytes as latched on E falling edges.
    always @(negedge E) cap.push_back({RS, DB});

    always @(negedge mclk) if (frame_done) fd_q.push_back(cyc);

    task automatic wait_cap(input int n, input int budget, output bit ok);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            @(posedge mclk); #2;
            k++;
        end
        ok = (cap.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        vec_cnt++; if ({DB, RS, E, RW, frame_done} !== 12'h000) begin
            miss_cnt++; $display("FAIL reset_outputs: got DB=%02h RS=%b E=%b RW=%b fd=%b expected all 0", DB, RS, E, RW, frame_done);
        end
        rst = 1'b0;
        cap.delete();
        for (int k = 1; k <= 4; k++) begin
            @(posedge mclk); #1;
            vec_cnt++; if (E !== 1'b0) begin
                miss_cnt++; $display("FAIL reset_e_low[%0d]: got %b expected 0", k, E);
            end
        end
        @(posedge mclk); #1;
        vec_cnt++; if ({E, RS, DB} !== 10'h238) begin
            miss_cnt++; $display("FAIL first_e_rise: got E=%b RS=%b DB=%02h expected E=1 RS=0 DB=38", E, RS, DB);
        end
    endtask

    task automatic test_init();
        logic [8:0] exp_tab[23] = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006, 9'h040,
                                    9'h104, 9'h10E, 9'h10E, 9'h10E, 9'h11F, 9'h100, 9'h104, 9'h100,
                                    9'h11F, 9'h111, 9'h10A, 9'h104, 9'h10A, 9'h111, 9'h11F, 9'h100};
        bit ok;
        wait_cap(23, 600, ok);
        vec_cnt++; if (!ok) begin
            miss_cnt++; $display("FAIL init_timeout: got %0d bytes expected 23", cap.size());
        end else begin
            for (int i = 0; i < 23; i++) begin
                vec_cnt++; if (cap[i] !== exp_tab[i]) begin
                    miss_cnt++; $display("FAIL init_byte[%0d]: got %03h expected %03h", i, cap[i], exp_tab[i]);
                end
            end
        end
    endtask

    task automatic test_frame();
        logic [8:0] exp_b;
        bit ok;
        wait_cap(57, 800, ok);
        vec_cnt++; if (!ok) begin
            miss_cnt++; $display("FAIL frame_timeout: got %0d bytes expected 57", cap.size());
        end else begin
            for (int i = 0; i < 34; i++) begin
                if (i == 0)       exp_b = 9'h080;
                else if (i < 17)  exp_b = 9'h141 + 9'(i - 1);
                else if (i == 17) exp_b = 9'h0C0;
                else              exp_b = 9'h130;
                vec_cnt++; if (cap[23 + i] !== exp_b) begin
                    miss_cnt++; $display("FAIL frame_byte[%0d]: got %03h expected %03h", i, cap[23 + i], exp_b);
                end
            end
        end
    endtask

    task automatic test_anti_tear();
        int n0 = fd_q.size();
        int base;
        int k = 0;
        bit ok;
        while (fd_q.size() <= n0 && k < 1500) begin
            @(posedge mclk); #2;
            k++;
        end
        base = cap.size();
        wait_cap(base + 5, 800, ok);
        for (int i = 0; i < 16; i++) LineA[8*i +: 8] = 8'h20;
        wait_cap(base + 68, 2000, ok);
        vec_cnt++; if (!ok || fd_q.size() <= n0) begin
            miss_cnt++; $display("FAIL anti_tear_timeout: got %0d bytes expected %0d", cap.size(), base + 68);
        end else begin
            for (int i = 0; i < 16; i++) begin
                vec_cnt++; if (cap[base + 1 + i] !== 9'h141 + 9'(i)) begin
                    miss_cnt++; $display("FAIL tear_old[%0d]: got %03h expected %03h", i, cap[base + 1 + i], 9'h141 + 9'(i));
                end
                vec_cnt++; if (cap[base + 35 + i] !== 9'h120) begin
                    miss_cnt++; $display("FAIL tear_new[%0d]: got %03h expected 120", i, cap[base + 35 + i]);
                end
            end
        end
    endtask

    task automatic test_protocol();
        int n0 = fd_q.size();
        int k = 0;
        int run = 0;
        bit pe, chg;
        logic [8:0] pbus, bus;
        @(posedge mclk); #2;
        pe = E; pbus = {RS, DB}; chg = 1'b0;
        while (fd_q.size() < n0 + 2 && k < 2000) begin
            @(posedge mclk); #2;
            k++;
            bus = {RS, DB};
            if (chg) begin
                vec_cnt++; if (!(E && !pe)) begin
                    miss_cnt++; $display("FAIL setup_then_rise: cycle %0d got E=%b expected rise", cyc, E);
                end
            end
            if (E || pe) begin
                vec_cnt++; if (bus !== pbus) begin
                    miss_cnt++; $display("FAIL bus_stable: cycle %0d got %03h expected %03h", cyc, bus, pbus);
                end
            end
            if (E) run = pe ? run + 1 : 1;
            if (!E && pe) begin
                vec_cnt++; if (run != 2) begin
                    miss_cnt++; $display("FAIL e_width: got %0d expected 2", run);
                end
            end
            chg = (bus !== pbus);
            pe = E; pbus = bus;
        end
        vec_cnt++; if (fd_q.size() < n0 + 2) begin
            miss_cnt++; $display("FAIL frame_done_timeout: got %0d pulses expected 2", fd_q.size() - n0);
        end else begin
            vec_cnt++; if (fd_q[n0 + 1] - fd_q[n0] != 762) begin
                miss_cnt++; $display("FAIL frame_period: got %0d expected 762", fd_q[n0 + 1] - fd_q[n0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int k = 0;
        bit ok;
        while (!(E === 1'b1 && RS === 1'b1) && k < 1500) begin
            @(posedge mclk); #2;
            k++;
        end
        vec_cnt++; if (!(E === 1'b1 && RS === 1'b1)) begin
            miss_cnt++; $display("FAIL mid_find_data: got E=%b RS=%b expected 1 1", E, RS);
        end
        rst = 1'b1;
        @(posedge mclk); #1;
        vec_cnt++; if ({DB, RS, E, RW, frame_done} !== 12'h000) begin
            miss_cnt++; $display("FAIL mid_reset_outputs: got DB=%02h RS=%b E=%b RW=%b fd=%b expected all 0", DB, RS, E, RW, frame_done);
        end
        rst = 1'b0;
        cap.delete();
        for (int j = 1; j <= 4; j++) begin
            @(posedge mclk); #1;
            vec_cnt++; if (E !== 1'b0) begin
                miss_cnt++; $display("FAIL mid_e_low[%0d]: got %b expected 0", j, E);
            end
        end
        @(posedge mclk); #1;
        vec_cnt++; if ({E, RS, DB} !== 10'h238) begin
            miss_cnt++; $display("FAIL mid_first_rise: got E=%b RS=%b DB=%02h expected E=1 RS=0 DB=38", E, RS, DB);
        end
        wait_cap(1, 50, ok);
        vec_cnt++; if (!ok || cap[0] !== 9'h038) begin
            miss_cnt++; $display("FAIL mid_first_byte: got %0d bytes first=%03h expected 038", cap.size(), ok ? cap[0] : 9'h000);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            LineA[8*i +: 8] = 8'h41 + 8'(i);
            LineB[8*i +: 8] = 8'h30;
        end
        test_reset();
        test_init();
        test_frame();
        test_anti_tear();
        test_protocol();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
